// File: rtl/lfsr_stream_checker.sv
// Receive-side checker for a 16-bit Galois LFSR word stream: predicts, locks, flags and counts deviations.
// Define LFSR_CHK_PERIOD_EN to add sequence-period measurement (PERIOD/PERIOD_VALID tie to 0 otherwise).
module lfsr_stream_checker #(
  parameter logic [15:0] TAPS     = 16'h6B8E,
  parameter int unsigned LOCK_LEN = 8,
  parameter logic [7:0]  ERR_MAX  = 8'hFF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        clear_i,
  input  logic [15:0] data_in_i,
  input  logic        data_valid_i,
  output logic        locked_o,
  output logic        error_o,
  output logic [7:0]  err_count_o,
  output logic        zero_fault_o,
  output logic [16:0] period_o,
  output logic        period_valid_o
);

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_e;

  localparam logic [8:0] LOCK_LEN_W = 9'(LOCK_LEN);

  state_e      state_q, state_d;
  logic [15:0] prev_q, prev_d;
  logic [7:0]  run_q, run_d;
  logic        error_q, error_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        zero_q, zero_d;
  logic [15:0] pred;
  logic        match;

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    run_d     = run_q;
    error_d   = error_q;
    err_cnt_d = err_cnt_q;
    zero_d    = zero_q;
    pred      = {prev_q[14:0], prev_q[15]} ^ ({16{prev_q[15]}} & TAPS);
    // The all-zero lockup word is never accepted as a correct prediction.
    match     = (data_in_i == pred) && (data_in_i != 16'h0000);
    if (clear_i) begin
      state_d   = IDLE;
      prev_d    = '0;
      run_d     = '0;
      error_d   = 1'b0;
      err_cnt_d = '0;
      zero_d    = 1'b0;
    end else if (data_valid_i) begin
      prev_d = data_in_i;
      if (data_in_i == 16'h0000) zero_d = 1'b1;
      case (state_q)
        IDLE: begin
          run_d   = '0;
          state_d = TRACK;
        end
        TRACK: begin
          if (match) begin
            run_d = run_q + 8'd1;
            if (({1'b0, run_q} + 9'd1) == LOCK_LEN_W) state_d = LOCKED;
          end else begin
            run_d = '0;
          end
        end
        LOCKED: begin
          if (!match) begin
            error_d = 1'b1;
            if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 8'd1;
            run_d   = '0;
            state_d = TRACK;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      run_q     <= '0;
      error_q   <= 1'b0;
      err_cnt_q <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      run_q     <= run_d;
      error_q   <= error_d;
      err_cnt_q <= err_cnt_d;
      zero_q    <= zero_d;
    end
  end

  assign locked_o     = (state_q == LOCKED);
  assign error_o      = error_q;
  assign err_count_o  = err_cnt_q;
  assign zero_fault_o = zero_q;

`ifdef LFSR_CHK_PERIOD_EN
  logic [15:0] anchor_q, anchor_d;
  logic [16:0] cnt_q, cnt_d, cnt_inc;
  logic        meas_q, meas_d;
  logic [16:0] period_q, period_d;
  logic        pvalid_q, pvalid_d;

  // Only the first lock after a clear is measured; a mismatch abandons the attempt.
  always_comb begin
    anchor_d = anchor_q;
    cnt_d    = cnt_q;
    meas_d   = meas_q;
    period_d = period_q;
    pvalid_d = pvalid_q;
    cnt_inc  = (cnt_q == 17'h1FFFF) ? cnt_q : cnt_q + 17'd1;
    if (clear_i) begin
      anchor_d = '0;
      cnt_d    = '0;
      meas_d   = 1'b0;
      period_d = '0;
      pvalid_d = 1'b0;
    end else if (data_valid_i) begin
      if (state_q == TRACK && state_d == LOCKED) begin
        if (!pvalid_q) begin
          anchor_d = data_in_i;
          cnt_d    = '0;
          meas_d   = 1'b1;
        end
      end else if (state_q == LOCKED) begin
        if (!match) begin
          meas_d = 1'b0;
        end else if (meas_q) begin
          cnt_d = cnt_inc;
          if (data_in_i == anchor_q) begin
            period_d = cnt_inc;
            pvalid_d = 1'b1;
            meas_d   = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      anchor_q <= '0;
      cnt_q    <= '0;
      meas_q   <= 1'b0;
      period_q <= '0;
      pvalid_q <= 1'b0;
    end else begin
      anchor_q <= anchor_d;
      cnt_q    <= cnt_d;
      meas_q   <= meas_d;
      period_q <= period_d;
      pvalid_q <= pvalid_d;
    end
  end

  assign period_o       = period_q;
  assign period_valid_o = pvalid_q;
`else
  assign period_o       = '0;
  assign period_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Self-checking bench for lfsr_stream_checker: two instances (LOCK_LEN 8 and 1) against a behavioural model.
// Honours LFSR_CHK_PERIOD_EN to also exercise the full-period measurement.
module tb_lfsr_stream_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN;
  logic        clrA, vA, clrB, vB;
  logic [15:0] dA, dB;
  logic        lockedA, errorA, zeroA, pvA;
  logic        lockedB, errorB, zeroB, pvB;
  logic [7:0]  errCntA, errCntB;
  logic [16:0] periodA, periodB;

  lfsr_stream_checker #(.LOCK_LEN(8)) dutA (
    .clk_i(clk), .rst_n_i(rstN), .clear_i(clrA), .data_in_i(dA), .data_valid_i(vA),
    .locked_o(lockedA), .error_o(errorA), .err_count_o(errCntA), .zero_fault_o(zeroA),
    .period_o(periodA), .period_valid_o(pvA));

  lfsr_stream_checker #(.LOCK_LEN(1)) dutB (
    .clk_i(clk), .rst_n_i(rstN), .clear_i(clrB), .data_in_i(dB), .data_valid_i(vB),
    .locked_o(lockedB), .error_o(errorB), .err_count_o(errCntB), .zero_fault_o(zeroB),
    .period_o(periodB), .period_valid_o(pvB));

  typedef struct {
    int          lockLen;
    bit          havePrev;
    bit          locked;
    bit          err;
    bit          zero;
    bit          periodValid;
    bit          measuring;
    logic [15:0] prev;
    logic [15:0] anchor;
    int          run;
    int          errCnt;
    int          period;
    int          cnt;
  } modelT;

  modelT mA, mB;
  int testsRun = 0;
  int testsFailed = 0;
  bit checkEn = 1'b0;
  logic [15:0] w, bad;

  // Next LFSR word computed arithmetically: double, wrap, feed the old top bit back, then apply taps.
  function automatic logic [15:0] lfsrNext(input logic [15:0] p);
    int v;
    int msb;
    v   = int'(p);
    msb = v / 32768;
    v   = (v * 2) % 65536 + msb;
    if (msb == 1) v = v ^ 32'h6B8E;
    return v[15:0];
  endfunction

  function automatic modelT modelReset(input int lockLen);
    modelT m;
    m.lockLen = lockLen;
    m.havePrev = 0; m.locked = 0; m.err = 0; m.zero = 0;
    m.periodValid = 0; m.measuring = 0;
    m.prev = '0; m.anchor = '0;
    m.run = 0; m.errCnt = 0; m.period = 0; m.cnt = 0;
    return m;
  endfunction

  function automatic modelT modelStep(input modelT mi, input bit clr, input bit v, input logic [15:0] d);
    modelT m;
    bit good;
    m = mi;
    if (clr) return modelReset(mi.lockLen);
    if (!v) return m;
    if (d == 16'h0000) m.zero = 1;
    good = m.havePrev && (d != 16'h0000) && (d == lfsrNext(m.prev));
    if (!m.havePrev) begin
      m.havePrev = 1;
      m.run = 0;
    end else if (m.locked) begin
      if (!good) begin
        m.err = 1;
        if (m.errCnt < 255) m.errCnt++;
        m.locked = 0;
        m.run = 0;
        m.measuring = 0;
      end else if (m.measuring) begin
        if (m.cnt < 131071) m.cnt++;
        if (d == m.anchor) begin
          m.period = m.cnt;
          m.periodValid = 1;
          m.measuring = 0;
        end
      end
    end else if (good) begin
      m.run++;
      if (m.run == m.lockLen) begin
        m.locked = 1;
`ifdef LFSR_CHK_PERIOD_EN
        if (!m.periodValid) begin
          m.measuring = 1;
          m.anchor = d;
          m.cnt = 0;
        end
`endif
      end
    end else begin
      m.run = 0;
    end
    m.prev = d;
    return m;
  endfunction

  task automatic compare(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput(input string tag, input modelT m, input logic locked, input logic error,
                             input logic [7:0] errCnt, input logic zero, input logic [16:0] period,
                             input logic pv);
    compare({tag, ".locked"}, int'(locked), int'(m.locked));
    compare({tag, ".error"}, int'(error), int'(m.err));
    compare({tag, ".errCount"}, int'(errCnt), m.errCnt);
    compare({tag, ".zeroFault"}, int'(zero), int'(m.zero));
    compare({tag, ".period"}, int'(period), m.period);
    compare({tag, ".periodValid"}, int'(pv), int'(m.periodValid));
  endtask

  // Model advances on the same edge the DUT samples; inputs are stable there.
  always @(posedge clk) begin
    if (!rstN) begin
      mA = modelReset(8);
      mB = modelReset(1);
    end else begin
      mA = modelStep(mA, clrA, vA, dA);
      mB = modelStep(mB, clrB, vB, dB);
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("A", mA, lockedA, errorA, errCntA, zeroA, periodA, pvA);
      checkOutput("B", mB, lockedB, errorB, errCntB, zeroB, periodB, pvB);
    end
  end

  task automatic applyStimulus(input bit sel, input bit clr, input bit v, input logic [15:0] d);
    clrA = 1'b0; vA = 1'b0; dA = 16'($urandom);
    clrB = 1'b0; vB = 1'b0; dB = 16'($urandom);
    if (!sel) begin
      clrA = clr; vA = v; dA = d;
    end else begin
      clrB = clr; vB = v; dB = d;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic randomGaps();
    repeat ($urandom_range(0, 2)) applyStimulus(0, 0, 0, 16'h0000);
  endtask

  initial begin
    rstN = 1'b0;
    applyStimulus(0, 0, 0, 16'h0000);
    applyStimulus(0, 0, 0, 16'h0000);
    checkEn = 1'b1;
    compare("resetLocked", int'(lockedA), 0);
    compare("resetErrCount", int'(errCntA), 0);
    compare("resetZero", int'(zeroA), 0);
    rstN = 1'b1;

    compare("modelPinBA12", int'(lfsrNext(16'h5D09)), 32'hBA12);
    compare("modelPin1FAB", int'(lfsrNext(16'hBA12)), 32'h1FAB);

    // Acquisition from the seed: lock on the 9th word.
    w = 16'h5D09;
    applyStimulus(0, 0, 1, w);
    for (int i = 1; i <= 8; i++) begin
      w = lfsrNext(w);
      applyStimulus(0, 0, 1, w);
      if (i == 7) compare("notLockedAt8thWord", int'(lockedA), 0);
      if (i == 8) compare("lockedAt9thWord", int'(lockedA), 1);
    end
    compare("noErrorAfterLock", int'(errorA), 0);
    compare("errCountAfterLock", int'(errCntA), 0);
    repeat (20) begin
      if ($urandom_range(0, 2) == 0) applyStimulus(0, 0, 0, 16'h0000);
      else begin
        w = lfsrNext(w);
        applyStimulus(0, 0, 1, w);
      end
    end

    // Single injected word, then the true sequence continuing from it.
    w = 16'h1234;
    applyStimulus(0, 0, 1, w);
    compare("injectError", int'(errorA), 1);
    compare("injectErrCount", int'(errCntA), 1);
    compare("injectUnlock", int'(lockedA), 0);
    for (int i = 1; i <= 8; i++) begin
      randomGaps();
      w = lfsrNext(w);
      applyStimulus(0, 0, 1, w);
      if (i == 7) compare("relockNotYet", int'(lockedA), 0);
      if (i == 8) compare("relockAfter8", int'(lockedA), 1);
    end
    compare("errorSticky", int'(errorA), 1);

    // Randomised mix of true steps, corrupt words, zeros and gaps.
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 4) applyStimulus(0, 0, 0, 16'h0000);
      else if (r < 6) begin
        w = 16'($urandom);
        applyStimulus(0, 0, 1, w);
      end else if (r == 6) begin
        w = 16'h0000;
        applyStimulus(0, 0, 1, w);
      end else begin
        w = lfsrNext(w);
        applyStimulus(0, 0, 1, w);
      end
    end

    // Clear while locked with ERROR set, then fresh acquisition across gaps.
    w = 16'hACE1;
    for (int i = 0; i < 10; i++) begin
      w = lfsrNext(w);
      applyStimulus(0, 0, 1, w);
    end
    compare("preClearLocked", int'(lockedA), 1);
    compare("preClearError", int'(errorA), 1);
    applyStimulus(0, 1, 1, lfsrNext(w));
    compare("clearLocked", int'(lockedA), 0);
    compare("clearError", int'(errorA), 0);
    compare("clearErrCount", int'(errCntA), 0);
    compare("clearZero", int'(zeroA), 0);
    for (int i = 1; i <= 9; i++) begin
      randomGaps();
      w = lfsrNext(w);
      applyStimulus(0, 0, 1, w);
      if (i == 8) compare("reacqNotYet", int'(lockedA), 0);
      if (i == 9) compare("reacqLocked", int'(lockedA), 1);
    end

    // Zeros while tracking.
    applyStimulus(0, 1, 0, 16'h0000);
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 1, 16'h0000);
    compare("zeroFault", int'(zeroA), 1);
    compare("zeroNoLock", int'(lockedA), 0);

    // Reset while locked.
    w = 16'h5D09;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 0, 1, w);
      w = lfsrNext(w);
    end
    compare("preResetLocked", int'(lockedA), 1);
    rstN = 1'b0;
    applyStimulus(0, 0, 1, w);
    rstN = 1'b1;
    compare("resetMidLocked", int'(lockedA), 0);
    compare("resetMidZero", int'(zeroA), 0);

    // LOCK_LEN=1 instance: alternate lock and break until the counter saturates.
    w = 16'h5D09;
    applyStimulus(1, 0, 1, w);
    for (int k = 0; k < 300; k++) begin
      w = lfsrNext(w);
      applyStimulus(1, 0, 1, w);
      if (k == 0) compare("lockLen1Locked", int'(lockedB), 1);
      bad = lfsrNext(w) ^ 16'h0001;
      if (bad == 16'h0000) bad = 16'h0003;
      w = bad;
      applyStimulus(1, 0, 1, w);
      if (k == 253) compare("errCount254", int'(errCntB), 254);
      if (k == 254) compare("errCountSat", int'(errCntB), 255);
    end
    compare("errCountNoWrap", int'(errCntB), 255);

`ifdef LFSR_CHK_PERIOD_EN
    applyStimulus(0, 1, 0, 16'h0000);
    w = 16'h5D09;
    for (int i = 0; i < 65545; i++) begin
      applyStimulus(0, 0, 1, w);
      w = lfsrNext(w);
    end
    compare("periodValid", int'(pvA), 1);
    compare("period65535", int'(periodA), 65535);
`else
    compare("periodOff", int'(periodA), 0);
    compare("periodValidOff", int'(pvA), 0);
`endif

    applyStimulus(0, 0, 0, 16'h0000);
    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
